// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and defaults for the IF/MEM unified-memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int LAT_DEF        = 2;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // Bits needed to hold values 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response signals plus the memory-side bus of the arbiter.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_rd, mem_wr, mem_addr, mem_wdata, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_rd, mem_wr, mem_addr, mem_wdata, stall
    );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// Combinational grant select: data wins unless fetch has been starved STARVE_MAX times.
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int SW         = cnt_w(STARVE_MAX + 1)
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] starve,
    output logic          gnt_vld,
    output logic          gnt
);

    always_comb begin
        gnt_vld = if_req | d_req;
        gnt     = GNT_D;
        if (!d_req)
            gnt = GNT_IF;
        else if (if_req && starve == SW'(STARVE_MAX))
            gnt = GNT_IF;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data stages with a fixed
// access latency, per-requester ack/rdata and a global pipeline stall.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT        = LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int CW = cnt_w(LAT);
    localparam int SW = cnt_w(STARVE_MAX + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starve;
    logic          gnt;
    logic          we_l;
    logic [31:0]   addr_l;
    logic [31:0]   wdata_l;
    logic          pick_vld;
    logic          pick;
    logic          last_beat;

    mem_arb_priority #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_prio (
        .if_req  (bus.if_req),
        .d_req   (bus.d_req),
        .starve  (starve),
        .gnt_vld (pick_vld),
        .gnt     (pick)
    );

    assign last_beat = (state == ACCESS) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // RESP never arbitrates: the acked requester's req is still stale there.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = ACCESS;
            ACCESS:  if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            starve  <= '0;
            gnt     <= GNT_IF;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
        end else if (state == IDLE && pick_vld) begin
            gnt     <= pick;
            cnt     <= CW'(LAT - 1);
            we_l    <= (pick == GNT_D) ? bus.d_we : 1'b0;
            addr_l  <= (pick == GNT_D) ? bus.d_addr : bus.if_addr;
            wdata_l <= (pick == GNT_D) ? bus.d_wdata : '0;
            if (pick == GNT_IF)
                starve <= '0;
            else if (bus.if_req && starve != SW'(STARVE_MAX))
                starve <= starve + SW'(1);
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.if_ack   <= 1'b0;
            bus.d_ack    <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
        end else begin
            bus.if_ack <= last_beat && (gnt == GNT_IF);
            bus.d_ack  <= last_beat && (gnt == GNT_D);
            if (last_beat && !we_l) begin
                if (gnt == GNT_IF) bus.if_rdata <= bus.mem_rdata;
                else               bus.d_rdata  <= bus.mem_rdata;
            end
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.mem_rd    = (state == ACCESS) && !we_l;
    assign bus.mem_wr    = (state == ACCESS) && we_l;
    assign bus.mem_addr  = addr_l;
    assign bus.mem_wdata = wdata_l;
    assign bus.stall     = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a schedule-level model.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: an access granted at cycle g_cyc strobes memory during
    // g_cyc+1..g_cyc+LAT, acks at g_cyc+LAT+1, and the port is free again after.
    bit          g_act = 1'b0;
    bit          g_d   = 1'b0;
    bit          g_we  = 1'b0;
    int          g_cyc = 0;
    int          starve = 0;
    logic [31:0] g_addr = '0;
    logic [31:0] g_wdata = '0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    bit          e_ia = 1'b0;
    bit          e_da = 1'b0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2002_0005 : ((a * 32'h9E37_79B1) ^ 32'h1234_5678);
    endfunction

    assign bus.mem_rdata = memfn(bus.mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        g_act      = 1'b0;
        starve     = 0;
        m_if_rdata = '0;
        m_d_rdata  = '0;
        e_ia       = 1'b0;
        e_da       = 1'b0;
    endtask

    task automatic settle_check();
        int k;
        bit e_rd, e_wr;
        #2;
        if (!g_act || cyc >= g_cyc + LAT + 2) begin
            g_act = 1'b0;
            if (bus.if_req || bus.d_req) begin
                g_d     = bus.d_req && !(bus.if_req && starve == SMAX);
                g_act   = 1'b1;
                g_cyc   = cyc;
                g_we    = g_d ? bus.d_we : 1'b0;
                g_addr  = g_d ? bus.d_addr : bus.if_addr;
                g_wdata = bus.d_wdata;
                if (!g_d) starve = 0;
                else if (bus.if_req && starve < SMAX) starve++;
            end
        end
        k    = cyc - g_cyc;
        e_rd = g_act && k >= 1 && k <= LAT && !g_we;
        e_wr = g_act && k >= 1 && k <= LAT && g_we;
        e_ia = g_act && k == LAT + 1 && !g_d;
        e_da = g_act && k == LAT + 1 && g_d;
        if (g_act && k == LAT + 1 && !g_we) begin
            if (g_d) m_d_rdata  = memfn(g_addr);
            else     m_if_rdata = memfn(g_addr);
        end
        chk("mem_rd", bus.mem_rd, e_rd);
        chk("mem_wr", bus.mem_wr, e_wr);
        if (e_rd || e_wr) chk("mem_addr", bus.mem_addr, g_addr);
        if (e_wr) chk("mem_wdata", bus.mem_wdata, g_wdata);
        chk("if_ack", bus.if_ack, e_ia);
        chk("d_ack", bus.d_ack, e_da);
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        chk("stall", bus.stall, (bus.if_req & !e_ia) | (bus.d_req & !e_da));
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_mem_rd"}, bus.mem_rd, 0);
        chk({pfx, "_mem_wr"}, bus.mem_wr, 0);
        chk({pfx, "_mem_addr"}, bus.mem_addr, 0);
        chk({pfx, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({pfx, "_if_ack"}, bus.if_ack, 0);
        chk({pfx, "_d_ack"}, bus.d_ack, 0);
        chk({pfx, "_if_rdata"}, bus.if_rdata, 0);
        chk({pfx, "_d_rdata"}, bus.d_rdata, 0);
        chk({pfx, "_stall"}, bus.stall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        int ph;
        bit if_p, d_p;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        settle_check(); tick();

        // Single fetch; address changes after grant must be ignored
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            chk("fetch_stall", bus.stall, k < 3);
            if (k == 1 || k == 2) begin
                chk("fetch_rd", bus.mem_rd, 1);
                chk("fetch_addr", bus.mem_addr, 32'h40);
            end
            if (k == 3) begin
                chk("fetch_ack", bus.if_ack, 1);
                chk("fetch_rdata", bus.if_rdata, 32'h2002_0005);
            end
            tick();
            if (k == 0) bus.if_addr = 32'hBAD0;
        end
        bus.if_req = 1'b0;
        settle_check(); tick();

        // Data write
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            if (k == 1 || k == 2) begin
                chk("wr_strobe", bus.mem_wr, 1);
                chk("wr_rd_low", bus.mem_rd, 0);
                chk("wr_addr", bus.mem_addr, 32'h100);
                chk("wr_data", bus.mem_wdata, 32'hDEAD_BEEF);
            end
            if (k == 3) begin
                chk("wr_ack", bus.d_ack, 1);
                chk("wr_rdata_kept", bus.d_rdata, 0);
            end
            tick();
            if (k == 1) bus.d_wdata = 32'h0BAD_0BAD;
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        settle_check(); tick();

        // Simultaneous requests: data first, fetch right after
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        for (int k = 0; k < 8; k++) begin
            settle_check();
            if (k == 3) begin
                chk("sim_d_ack", bus.d_ack, 1);
                chk("sim_if_ack_lo", bus.if_ack, 0);
                chk("sim_d_rdata", bus.d_rdata, memfn(32'h200));
            end
            if (k == 5) chk("sim_if_addr", bus.mem_addr, 32'h80);
            if (k == 7) chk("sim_if_ack", bus.if_ack, 1);
            tick();
            if (k == 3) bus.d_req = 1'b0;
        end
        bus.if_req = 1'b0;
        settle_check(); tick();

        // Starvation: D,D,D,IF twice (second round proves starve cleared)
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
        for (int k = 0; k < 32; k++) begin
            settle_check();
            if (bus.d_ack)  order.push_back(1);
            if (bus.if_ack) order.push_back(0);
            tick();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        chk("starve_nacks", order.size(), 8);
        for (int j = 0; j < 8; j++)
            if (j < order.size()) chk($sformatf("starve_g%0d", j), order[j], (j % 4 == 3) ? 0 : 1);
        settle_check(); tick();

        // Flush: fetch withdrawn during ACCESS still completes; data follows
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        settle_check(); tick();
        bus.if_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        for (int k = 1; k < 8; k++) begin
            settle_check();
            if (k == 3) chk("flush_if_ack", bus.if_ack, 1);
            if (k == 5) chk("flush_d_addr", bus.mem_addr, 32'h400);
            if (k == 7) begin
                chk("flush_d_ack", bus.d_ack, 1);
                chk("flush_d_rdata", bus.d_rdata, memfn(32'h400));
            end
            tick();
        end
        bus.d_req = 1'b0;
        settle_check(); tick();

        // Reset in the middle of a read access
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h500;
        ph = $urandom_range(1, LAT);
        for (int k = 0; k <= ph; k++) begin
            settle_check();
            if (k < ph) tick();
        end
        chk("rst_pre_rd", bus.mem_rd, 1);
        rst = 1'b1; bus.d_req = 1'b0;
        #1 chk_all_zero("rst_mid");
        model_reset();
        tick();
        rst = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h900;
        for (int k = 0; k < 4; k++) begin
            settle_check();
            if (k == 3) chk("post_rst_ack", bus.d_ack, 1);
            tick();
        end
        bus.d_req = 1'b0;
        settle_check(); tick();

        // Randomized traffic with flushes and address/data churn
        if_p = 1'b0; d_p = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (e_ia) if_p = 1'b0;
            if (e_da) d_p = 1'b0;
            if (!if_p && $urandom_range(0, 2) == 0) begin
                if_p = 1'b1; bus.if_addr = $urandom;
            end else if (if_p && $urandom_range(0, 15) == 0) begin
                if_p = 1'b0;
            end else if (if_p && $urandom_range(0, 3) == 0) begin
                bus.if_addr = $urandom;
            end
            if (!d_p && $urandom_range(0, 2) == 0) begin
                d_p = 1'b1; bus.d_addr = $urandom; bus.d_we = 1'($urandom_range(0, 1));
            end
            bus.d_wdata = $urandom;
            bus.if_req = if_p; bus.d_req = d_p;
            settle_check(); tick();
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            settle_check(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
